// File: rtl/spmv_row_accum_if.sv
// Operand-beat, result and pass-control signals shared by fetch, the row
// accumulator and write-back.
interface spmv_row_accum_if #(
  parameter int DW = 32,
  parameter int RW = 16
);
  logic          start;
  logic [RW-1:0] nrows;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_mval;
  logic [DW-1:0] in_vval;
  logic          in_last;
  logic          in_empty;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_row;
  logic [DW-1:0] out_data;
  logic          done;
  logic          ovf;

  modport master (
    output start, nrows, in_valid, in_mval, in_vval, in_last, in_empty, out_ready,
    input  in_ready, out_valid, out_row, out_data, done, ovf
  );

  modport slave (
    input  start, nrows, in_valid, in_mval, in_vval, in_last, in_empty, out_ready,
    output in_ready, out_valid, out_row, out_data, done, ovf
  );
endinterface

// File: rtl/spmv_row_accum.sv
// Sparse matrix-vector row accumulator: multiply stage, per-row accumulate
// stage and a small result FIFO toward write-back.
module spmv_row_accum #(
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  parameter int RW    = 16
) (
  input logic             Clk,
  input logic             Rst,
  spmv_row_accum_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = CW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  state_e state_q, state_d;

  logic [RW-1:0] nrows_q, rows_in_q, row_idx_q;
  logic          s1_valid_q, s1_close_q, s1_empty_q, s1_hi_q;
  logic [DW-1:0] s1_prod_q, acc_q;
  logic          r_valid_q;
  logic [RW-1:0] r_row_q;
  logic [DW-1:0] r_data_q;
  logic [RW-1:0] mem_row  [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          ovf_q, done_q;

  logic            start_acc, beat, close_beat, last_row, push, pop, fifo_nz;
  logic [2*DW-1:0] full_prod;
  logic [DW:0]     sum;
  logic [OW-1:0]   occupancy;

  // Closed rows still in the pipeline hold a FIFO slot, so a push never finds it full.
  assign occupancy  = {1'b0, cnt_q} + OW'(s1_valid_q && s1_close_q) + OW'(r_valid_q);
  assign start_acc  = (state_q == IDLE) && bus.start;
  assign beat       = bus.in_valid && bus.in_ready;
  assign close_beat = beat && (bus.in_last || bus.in_empty);
  assign last_row   = (rows_in_q == nrows_q - RW'(1));
  assign full_prod  = {{DW{1'b0}}, bus.in_mval} * {{DW{1'b0}}, bus.in_vval};
  assign sum        = {1'b0, acc_q} + {1'b0, s1_prod_q};
  assign fifo_nz    = (cnt_q != '0);
  assign push       = r_valid_q;
  assign pop        = fifo_nz && bus.out_ready;

  assign bus.in_ready  = (state_q == RUN) && (occupancy < OW'(DEPTH));
  assign bus.out_valid = fifo_nz;
  assign bus.out_row   = fifo_nz ? mem_row[rd_ptr_q]  : '0;
  assign bus.out_data  = fifo_nz ? mem_data[rd_ptr_q] : '0;
  assign bus.done      = done_q;
  assign bus.ovf       = ovf_q;

  // NOTE: every path assigns the default first, so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = (bus.nrows == '0) ? DONE : RUN;
      RUN:     if (close_beat && last_row) state_d = DRAIN;
      DRAIN:   if (!s1_valid_q && !r_valid_q && !fifo_nz) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      nrows_q    <= '0;
      rows_in_q  <= '0;
      row_idx_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_close_q <= 1'b0;
      s1_empty_q <= 1'b0;
      s1_hi_q    <= 1'b0;
      s1_prod_q  <= '0;
      acc_q      <= '0;
      r_valid_q  <= 1'b0;
      r_row_q    <= '0;
      r_data_q   <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      s1_valid_q <= beat;
      s1_close_q <= close_beat;
      s1_empty_q <= bus.in_empty;
      s1_prod_q  <= bus.in_empty ? '0 : full_prod[DW-1:0];
      s1_hi_q    <= !bus.in_empty && (full_prod[2*DW-1:DW] != '0);

      r_valid_q <= s1_valid_q && s1_close_q;
      if (s1_valid_q) begin
        if (s1_close_q) begin
          r_row_q   <= row_idx_q;
          r_data_q  <= s1_empty_q ? '0 : sum[DW-1:0];
          acc_q     <= '0;
          row_idx_q <= row_idx_q + RW'(1);
        end else begin
          acc_q <= sum[DW-1:0];
        end
        if (s1_hi_q || sum[DW]) ovf_q <= 1'b1;
      end

      if (close_beat) rows_in_q <= rows_in_q + RW'(1);

      if (start_acc) begin
        nrows_q   <= bus.nrows;
        rows_in_q <= '0;
        row_idx_q <= '0;
        acc_q     <= '0;
        ovf_q     <= 1'b0;
      end

      done_q <= (state_q == DONE);
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // NOTE: the storage array is not reset; the outputs are masked to zero while the FIFO is empty.
  always_ff @(posedge Clk) begin
    if (push) begin
      mem_row[wr_ptr_q]  <= r_row_q;
      mem_data[wr_ptr_q] <= r_data_q;
    end
  end
endmodule

// File: doc/spmv_row_accum.md
SPMV_ROW_ACCUM -- requirements
Module: spmv_row_accum

Interface
REQ-001 SHALL have parameter DW, default 32, the data width of operands and results.
REQ-002 SHALL have parameter DEPTH, default 4, the number of entries in the output result FIFO (power of two, at least 2).
REQ-003 SHALL have parameter RW, default 16, the width of the row index.
REQ-004 SHALL have port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port Rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port start, input, 1: one-cycle pulse in IDLE that begins a matrix pass.
REQ-007 SHALL have port nrows, input, RW: number of rows in the pass, sampled on start.
REQ-008 SHALL have ports in_valid (input, 1) and in_ready (output, 1): the operand-beat handshake from the control fetch stage.
REQ-009 SHALL have ports in_mval (input, DW) and in_vval (input, DW): the matrix nonzero value and the gathered vector value.
REQ-010 SHALL have port in_last, input, 1: the beat closes the current row.
REQ-011 SHALL have port in_empty, input, 1: the row has no nonzeros; operands are ignored and in_last is implied.
REQ-012 SHALL have ports out_valid (output, 1) and out_ready (input, 1): the result handshake toward write-back.
REQ-013 SHALL have ports out_row (output, RW) and out_data (output, DW): the row index and the y[row] value at the FIFO head.
REQ-014 SHALL have port done, output, 1: one-cycle pulse when the pass completes.
REQ-015 SHALL have port ovf, output, 1: sticky flag for arithmetic overflow during the pass.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DRAIN and DONE.
- IDLE to RUN on start with nrows>0.
- IDLE to DONE on start with nrows=0.
- RUN to DRAIN when the closing beat of row nrows-1 is accepted.
- DRAIN to DONE when the pipeline and FIFO are both empty.
- DONE to IDLE after one cycle.
REQ-017 SHALL ignore start outside IDLE.
REQ-018 SHALL transfer a beat only when in_valid and in_ready are both high at a rising edge.
REQ-019 SHALL drive in_ready = (state==RUN) and (fifo_count + pending_rows < DEPTH), where pending_rows is the number of closed rows still in the pipeline.
REQ-020 SHALL register the multiply in stage 1 as product = low DW bits of in_mval*in_vval (unsigned).
REQ-021 SHALL add each product into a DW-bit accumulator in stage 2, wrapping modulo 2^DW.
REQ-022 SHALL, on a closing beat, write {row_idx, acc+product} into the FIFO, clear the accumulator and increment row_idx.
REQ-023 SHALL write {row_idx, 0} for an in_empty beat, leaving no residue in the accumulator.
REQ-024 SHALL make a closing beat accepted at edge N appear as out_valid=1 after edge N+2 when the FIFO was empty (2-cycle latency).
REQ-025 SHALL pop the FIFO on out_valid and out_ready; a simultaneous push and pop leaves fifo_count unchanged, and FIFO pointers wrap modulo DEPTH.
REQ-026 SHALL hold out_row and out_data stable while out_valid=1 and out_ready=0.
REQ-027 SHALL set ovf if the upper DW bits of any full product are nonzero or any accumulate carries out; ovf holds until the next start or reset.
REQ-028 SHALL never drop or reorder results: row indices leave in strictly increasing order 0..nrows-1.
REQ-029 SHALL keep in_ready=0 in IDLE, DRAIN and DONE; beats offered there are not consumed.

Reset
REQ-030 SHALL, while Rst=0 (asynchronously), force state=IDLE, in_ready=0, out_valid=0, out_row=0, out_data=0, done=0, ovf=0, accumulator=0, row_idx=0 and FIFO empty.
REQ-031 SHALL, on reset mid-pass, discard all in-flight and buffered results and accept no beat until a new start after Rst returns high.

Verification
REQ-032 SHALL pass: start with nrows=2; row0 beats (76,47), (41,86,last); row1 (95,5,last) -> out (0,7098) then (1,475), done pulse, ovf=0.
REQ-033 SHALL pass: nrows=3, rows with one beat (18,39,last), an empty beat, and one beat (2,23,last) -> outputs (0,702), (1,0), (2,46).
REQ-034 SHALL pass: DEPTH=4, out_ready=0, six single-beat rows -> exactly 4 results buffered, in_ready=0; raising out_ready drains all 6 in order.
REQ-035 SHALL pass: beat (0xFFFFFFFF,2,last) -> out_data=0xFFFFFFFE, ovf=1 sticky until the next start.
REQ-036 SHALL pass: start with nrows=0 -> done pulses 2 cycles after start; no output.
REQ-037 SHALL pass: Rst asserted after two beats of a row -> all outputs at reset values immediately; the next pass starts at row 0 with a cleared accumulator.
